// File: rtl/rvc_asap_5pl_dma.sv
// rtl/rvc_asap_5pl_dma.sv - word-copy DMA initiator on the rvc_asap data-memory port
module rvc_asap_5pl_dma #(
    parameter int LEN_W = 16
) (
    input  logic             Clock,
    input  logic             Rst,
    input  logic             Start,
    input  logic [31:0]      SrcAddr,
    input  logic [31:0]      DstAddr,
    input  logic [LEN_W-1:0] Length,
    output logic             Busy,
    output logic             Done,
    output logic             Error,
    output logic             BusReq,
    input  logic             BusGnt,
    output logic [31:0]      data,
    output logic [31:0]      address,
    output logic [3:0]       byteena,
    output logic             wren,
    output logic             rden,
    input  logic [31:0]      q
);
    typedef enum logic [2:0] {S_IDLE, S_CHK, S_REQ, S_RD, S_WR, S_FIN} state_t;

    state_t           state;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] cnt_q;
    logic             err_q;
    logic             misaligned;

    assign misaligned = (src_q[1:0] != 2'b00) || (dst_q[1:0] != 2'b00);

    // Read data is forwarded straight from memory during the write cycle only.
    assign data = wren ? q : 32'h0;

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state   <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Error   <= 1'b0;
            BusReq  <= 1'b0;
            address <= '0;
            byteena <= '0;
            wren    <= 1'b0;
            rden    <= 1'b0;
        end else begin
            Done    <= 1'b0;
            Error   <= 1'b0;
            wren    <= 1'b0;
            rden    <= 1'b0;
            address <= '0;
            byteena <= '0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        src_q <= SrcAddr;
                        dst_q <= DstAddr;
                        cnt_q <= Length;
                        Busy  <= 1'b1;
                        state <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (misaligned) begin
                        err_q <= 1'b1;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        Error <= 1'b1;
                        state <= S_FIN;
                    end else if (cnt_q == '0) begin
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        BusReq <= 1'b1;
                        state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (BusGnt) begin
                        rden    <= 1'b1;
                        address <= src_q;
                        byteena <= 4'hF;
                        state   <= S_RD;
                    end
                end
                S_RD: begin
                    // The write always follows its read, even if grant was withdrawn.
                    wren    <= 1'b1;
                    address <= dst_q;
                    byteena <= 4'hF;
                    state   <= S_WR;
                end
                S_WR: begin
                    src_q <= src_q + 32'd4;
                    dst_q <= dst_q + 32'd4;
                    cnt_q <= cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        Busy   <= 1'b0;
                        BusReq <= 1'b0;
                        Done   <= 1'b1;
                        Error  <= err_q;
                        state  <= S_FIN;
                    end else if (BusGnt) begin
                        rden    <= 1'b1;
                        address <= src_q + 32'd4;
                        byteena <= 4'hF;
                        state   <= S_RD;
                    end else begin
                        state <= S_REQ;
                    end
                end
                S_FIN: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/rvc_asap_5pl_dma.md
# rvc_asap_5pl_dma

Word-copy DMA initiator for the rvc_asap 5-stage core's data-side memory interface. It drives the same `data`/`address`/`byteena`/`wren`/`rden`/`q` port set the core uses toward the memory wrapper, with its 1-cycle synchronous read latency. It can therefore copy blocks between D_MEM, CR_MEM and VGA regions with no changes to the memory side. An external arbiter multiplexes it against the core's memory stage using a `BusReq`/`BusGnt` handshake.

## Interface
Parameters:
- `LEN_W`, default 16: width of the word-count field; max transfer is 2^LEN_W − 1 words.

Ports:
- `Clock`  in  1  single clock, rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `Start`  in  1  one-cycle command strobe; sampled only in IDLE.
- `SrcAddr`  in  32  source byte address, latched on accepted `Start`.
- `DstAddr`  in  32  destination byte address, latched on accepted `Start`.
- `Length`  in  LEN_W  number of 32-bit words, latched on accepted `Start`.
- `Busy`  out  1  command in progress.
- `Done`  out  1  one-cycle completion pulse.
- `Error`  out  1  one-cycle pulse, coincident with `Done`, for a rejected command.
- `BusReq`  out  1  request for the memory interface.
- `BusGnt`  in  1  grant from the arbiter.
- `data`  out  32  write data to memory.
- `address`  out  32  byte address to memory.
- `byteena`  out  4  byte enables.
- `wren`  out  1  write enable.
- `rden`  out  1  read enable.
- `q`  in  32  read data, valid the cycle after `rden`.

## Operation
- States: IDLE, CHK, REQ, RD, WR, FIN.
- IDLE:
  - On `Start`=1, latch `SrcAddr`, `DstAddr`, `Length` into SrcQ, DstQ, CntQ, then go to CHK.
  - `Start` in any other state is ignored.
- CHK:
  - If SrcQ[1:0]≠0 or DstQ[1:0]≠0, set the error flag and go to FIN.
  - Else if CntQ==0, go to FIN with no bus activity.
  - Else go to REQ.
- REQ: `BusReq`=1. Go to RD when `BusGnt`=1 is sampled, otherwise stay.
- RD:
  - `BusReq`=1, `rden`=1, `address`=SrcQ, `byteena`=4'hF, `wren`=0.
  - Always go to WR.
- WR:
  - `BusReq`=1, `wren`=1, `address`=DstQ, `data`=`q`, `byteena`=4'hF, `rden`=0.
  - SrcQ += 4 and DstQ += 4, modulo 2^32 (wrap from 0xFFFFFFFC to 0 is legal).
  - CntQ −= 1.
  - If the new CntQ==0, go to FIN.
  - Else if `BusGnt`=1, go to RD.
  - Else go to REQ.
- FIN:
  - `Done`=1; `Error`=error flag.
  - Clear the error flag and return to IDLE.
- Grant protocol:
  - `BusGnt` is honoured only at word boundaries (REQ, and the exit from WR).
  - An RD is always followed by its WR even if `BusGnt` falls during RD; the arbiter must tolerate this one-cycle overrun.
- Overlapping regions: no special handling. Each word is read then written in order, so forward copy with DstQ>SrcQ overlap propagates data. This behaviour is defined and tested.
- Idle outputs: whenever not in RD/WR, `address`, `data`, `byteena`, `wren`, `rden` are all 0.

## Timing
- Reset value of every output is 0; state is IDLE; the error flag is cleared.
- `Rst` mid-transfer: the next cycle shows no `wren`/`rden`. A partially copied block stays partial. No `Done` is issued.
- Output timing: all outputs are registered from state except `data`, which is combinational from `q` during WR.
- Command flow, `Start` accepted at cycle T:
  - CHK at T+1, with `Busy`=1.
  - REQ at T+2.
  - With grant held, the first RD is at T+3.
  - The k-th word's RD is at T+1+2k and its WR at T+2+2k.
- Throughput: 2 cycles per word with grant held; N words give `Done` at T+3+2N.
- `Busy`: high from T+1 through the cycle before FIN; low in FIN (the `Done` cycle).
- Zero-length or misaligned command: `Done` at T+2, with no `BusReq`.
- Back-to-back commands: a new `Start` is accepted in the cycle after FIN, i.e. when IDLE is reached.

## Test plan
- Basic copy: preload src 0x1000..0x100C = {A,B,C,D}, Length=4, dst 0x2000, `BusGnt` tied 1 → exactly 4 read/write pairs at 0x1000/0x2000 … 0x100C/0x200C; dst holds {A,B,C,D}; `Done` at T+11; `Error`=0.
- Grant toggling: `BusGnt` drops during the 2nd RD and returns 5 cycles later → 2nd WR still issued; `BusReq` stays high in REQ; the 3rd RD follows 1 cycle after grant returns; final memory image is correct.
- Rejects:
  - SrcAddr=0x1002, Length=3 → `Done`=`Error`=1 at T+2; no `rden`/`wren`/`BusReq` ever.
  - Length=0 → `Done`=1, `Error`=0 at T+2.
- Wrap and overlap:
  - SrcAddr=0xFFFFFFFC, Length=2 → reads at 0xFFFFFFFC then 0x00000000.
  - src 0x1000, dst 0x1004, Length=3 → word at 0x1000 replicated into 0x1004..0x100C.
- Reset mid-transfer: assert `Rst` at the WR of word 2 of 8 → next cycle all outputs 0, no `Done`. A subsequent fresh command completes normally. `Start` pulsed while `Busy` is ignored (no re-latch; addresses unchanged).
